// File: rtl/mem_arbiter_pkg.sv
// Shared GPU package: arbiter FSM states plus the core and LSU state
// encodings used by the blocks around the data-memory channel.
//   arb_state_t  - mem_arbiter controller states
//   CORE_*       - core pipeline state encodings
//   LSU_*        - load/store unit state encodings
//   rr_wrap      - reduce an index in [0, 2n) to [0, n)
//   idx_bits     - width of an index over n items (at least 1)
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    READ_WAIT  = 2'd1,
    WRITE_WAIT = 2'd2,
    RELAY      = 2'd3
  } arb_state_t;

  localparam logic [2:0] CORE_IDLE    = 3'd0;
  localparam logic [2:0] CORE_FETCH   = 3'd1;
  localparam logic [2:0] CORE_DECODE  = 3'd2;
  localparam logic [2:0] CORE_REQUEST = 3'd3;
  localparam logic [2:0] CORE_WAIT    = 3'd4;
  localparam logic [2:0] CORE_EXECUTE = 3'd5;
  localparam logic [2:0] CORE_UPDATE  = 3'd6;
  localparam logic [2:0] CORE_DONE    = 3'd7;

  localparam logic [1:0] LSU_IDLE       = 2'd0;
  localparam logic [1:0] LSU_REQUESTING = 2'd1;
  localparam logic [1:0] LSU_WAITING    = 2'd2;
  localparam logic [1:0] LSU_DONE       = 2'd3;

  function automatic int rr_wrap(input int idx, input int n);
    return (idx >= n) ? idx - n : idx;
  endfunction

  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req          in   NUM_CONSUMERS  request vector
//   rr_ptr       in   IDX_BITS       first index to consider
//   grant_valid  out  1              some request is set
//   grant_index  out  IDX_BITS       first requester at or after rr_ptr (wrapping)
module rr_pick
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_CONSUMERS = 4,
  parameter int IDX_BITS      = 2
) (
  input  logic [NUM_CONSUMERS-1:0] req,
  input  logic [IDX_BITS-1:0]      rr_ptr,
  output logic                     grant_valid,
  output logic [IDX_BITS-1:0]      grant_index
);

  logic [IDX_BITS-1:0] w_k;

  always_comb begin
    grant_valid = 1'b0;
    grant_index = '0;
    w_k         = '0;
    for (int i = 0; i < NUM_CONSUMERS; i++) begin
      w_k = IDX_BITS'(rr_wrap(int'(rr_ptr) + i, NUM_CONSUMERS));
      if (!grant_valid && req[w_k]) begin
        grant_valid = 1'b1;
        grant_index = w_k;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one data-memory channel between LSUs.
//   clk                    in   1       rising-edge clock
//   reset                  in   1       async reset, active low
//   consumer_read_valid    in   N       per-LSU read request
//   consumer_read_address  in   N*A     per-LSU read address (LSU i at [i*A +: A])
//   consumer_read_ready    out  N       per-LSU read completion
//   consumer_read_data     out  N*D     per-LSU returned data
//   consumer_write_valid   in   N       per-LSU write request
//   consumer_write_address in   N*A     per-LSU write address
//   consumer_write_data    in   N*D     per-LSU write data
//   consumer_write_ready   out  N       per-LSU write completion
//   mem_read_valid/address out  1/A     channel read request
//   mem_read_ready/data    in   1/D     channel read acknowledge and data
//   mem_write_valid/address/data out 1/A/D channel write request
//   mem_write_ready        in   1       channel write acknowledge
//
// state      | meaning
// IDLE       | scanning from rr_ptr for a requester
// READ_WAIT  | channel read issued, holding until mem_read_ready
// WRITE_WAIT | channel write issued, holding until mem_write_ready
// RELAY      | completion shown to granted LSU until it drops valid
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
  output logic                               mem_read_valid,
  output logic [ADDR_BITS-1:0]               mem_read_address,
  input  logic                               mem_read_ready,
  input  logic [DATA_BITS-1:0]               mem_read_data,
  output logic                               mem_write_valid,
  output logic [ADDR_BITS-1:0]               mem_write_address,
  output logic [DATA_BITS-1:0]               mem_write_data,
  input  logic                               mem_write_ready
);

  localparam int IDX_BITS = idx_bits(NUM_CONSUMERS);

  arb_state_t                r_state, w_state_next;
  logic [IDX_BITS-1:0]       r_grant, w_grant_next;
  logic [IDX_BITS-1:0]       r_rr_ptr, w_rr_ptr_next;
  logic                      r_mem_read_valid, w_mem_read_valid_next;
  logic [ADDR_BITS-1:0]      r_mem_read_address, w_mem_read_address_next;
  logic                      r_mem_write_valid, w_mem_write_valid_next;
  logic [ADDR_BITS-1:0]      r_mem_write_address, w_mem_write_address_next;
  logic [DATA_BITS-1:0]      r_mem_write_data, w_mem_write_data_next;
  logic [NUM_CONSUMERS-1:0]  r_read_ready, w_read_ready_next;
  logic [NUM_CONSUMERS-1:0]  r_write_ready, w_write_ready_next;
  logic [DATA_BITS-1:0]      r_read_data [NUM_CONSUMERS];
  logic [DATA_BITS-1:0]      w_read_data_next [NUM_CONSUMERS];

  logic [ADDR_BITS-1:0]      w_rd_addr [NUM_CONSUMERS];
  logic [ADDR_BITS-1:0]      w_wr_addr [NUM_CONSUMERS];
  logic [DATA_BITS-1:0]      w_wr_data [NUM_CONSUMERS];
  logic [NUM_CONSUMERS-1:0]  w_req;
  logic                      w_pick_valid;
  logic [IDX_BITS-1:0]       w_pick_index;
  logic                      w_relay_done;

  for (genvar gi = 0; gi < NUM_CONSUMERS; gi++) begin : g_lanes
    assign w_rd_addr[gi] = consumer_read_address[gi*ADDR_BITS +: ADDR_BITS];
    assign w_wr_addr[gi] = consumer_write_address[gi*ADDR_BITS +: ADDR_BITS];
    assign w_wr_data[gi] = consumer_write_data[gi*DATA_BITS +: DATA_BITS];
    assign consumer_read_data[gi*DATA_BITS +: DATA_BITS] = r_read_data[gi];
  end

  assign w_req = consumer_read_valid | consumer_write_valid;

  rr_pick #(
    .NUM_CONSUMERS (NUM_CONSUMERS),
    .IDX_BITS      (IDX_BITS)
  ) u_rr_pick (
    .req         (w_req),
    .rr_ptr      (r_rr_ptr),
    .grant_valid (w_pick_valid),
    .grant_index (w_pick_index)
  );

  // RELAY ends once the LSU drops the valid matching the completion it was given.
  assign w_relay_done = (r_read_ready[r_grant]  && !consumer_read_valid[r_grant]) ||
                        (r_write_ready[r_grant] && !consumer_write_valid[r_grant]);

  always_comb begin
    w_state_next             = r_state;
    w_grant_next             = r_grant;
    w_rr_ptr_next            = r_rr_ptr;
    w_mem_read_valid_next    = r_mem_read_valid;
    w_mem_read_address_next  = r_mem_read_address;
    w_mem_write_valid_next   = r_mem_write_valid;
    w_mem_write_address_next = r_mem_write_address;
    w_mem_write_data_next    = r_mem_write_data;
    w_read_ready_next        = r_read_ready;
    w_write_ready_next       = r_write_ready;
    w_read_data_next         = r_read_data;

    case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_grant_next = w_pick_index;
          // Read wins when one LSU raises both; its write is picked up on a later grant.
          if (consumer_read_valid[w_pick_index]) begin
            w_mem_read_valid_next   = 1'b1;
            w_mem_read_address_next = w_rd_addr[w_pick_index];
            w_state_next            = READ_WAIT;
          end else begin
            w_mem_write_valid_next   = 1'b1;
            w_mem_write_address_next = w_wr_addr[w_pick_index];
            w_mem_write_data_next    = w_wr_data[w_pick_index];
            w_state_next             = WRITE_WAIT;
          end
        end
      end
      READ_WAIT: begin
        if (mem_read_ready) begin
          w_mem_read_valid_next     = 1'b0;
          w_read_data_next[r_grant] = mem_read_data;
          w_read_ready_next[r_grant] = 1'b1;
          w_state_next              = RELAY;
        end
      end
      WRITE_WAIT: begin
        if (mem_write_ready) begin
          w_mem_write_valid_next      = 1'b0;
          w_write_ready_next[r_grant] = 1'b1;
          w_state_next                = RELAY;
        end
      end
      RELAY: begin
        if (w_relay_done) begin
          w_read_ready_next  = '0;
          w_write_ready_next = '0;
          w_rr_ptr_next      = (r_grant == IDX_BITS'(NUM_CONSUMERS - 1)) ? '0 : r_grant + 1'b1;
          w_state_next       = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state             <= IDLE;
      r_grant             <= '0;
      r_rr_ptr            <= '0;
      r_mem_read_valid    <= 1'b0;
      r_mem_read_address  <= '0;
      r_mem_write_valid   <= 1'b0;
      r_mem_write_address <= '0;
      r_mem_write_data    <= '0;
      r_read_ready        <= '0;
      r_write_ready       <= '0;
      for (int i = 0; i < NUM_CONSUMERS; i++) begin
        r_read_data[i] <= '0;
      end
    end else begin
      r_state             <= w_state_next;
      r_grant             <= w_grant_next;
      r_rr_ptr            <= w_rr_ptr_next;
      r_mem_read_valid    <= w_mem_read_valid_next;
      r_mem_read_address  <= w_mem_read_address_next;
      r_mem_write_valid   <= w_mem_write_valid_next;
      r_mem_write_address <= w_mem_write_address_next;
      r_mem_write_data    <= w_mem_write_data_next;
      r_read_ready        <= w_read_ready_next;
      r_write_ready       <= w_write_ready_next;
      for (int i = 0; i < NUM_CONSUMERS; i++) begin
        r_read_data[i] <= w_read_data_next[i];
      end
    end
  end

  assign mem_read_valid       = r_mem_read_valid;
  assign mem_read_address     = r_mem_read_address;
  assign mem_write_valid      = r_mem_write_valid;
  assign mem_write_address    = r_mem_write_address;
  assign mem_write_data       = r_mem_write_data;
  assign consumer_read_ready  = r_read_ready;
  assign consumer_write_ready = r_write_ready;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic reset;
  logic [N-1:0]    rv, wv, rrdy, wrdy;
  logic [N*AW-1:0] ra, wa;
  logic [N*DW-1:0] wd, rdata;
  logic            mrv, mrr, mwv, mwr;
  logic [AW-1:0]   mra, mwa;
  logic [DW-1:0]   mrd, mwd;

  mem_arbiter #(.ADDR_BITS(AW), .DATA_BITS(DW), .NUM_CONSUMERS(N)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .consumer_read_valid    (rv),
    .consumer_read_address  (ra),
    .consumer_read_ready    (rrdy),
    .consumer_read_data     (rdata),
    .consumer_write_valid   (wv),
    .consumer_write_address (wa),
    .consumer_write_data    (wd),
    .consumer_write_ready   (wrdy),
    .mem_read_valid         (mrv),
    .mem_read_address       (mra),
    .mem_read_ready         (mrr),
    .mem_read_data          (mrd),
    .mem_write_valid        (mwv),
    .mem_write_address      (mwa),
    .mem_write_data         (mwd),
    .mem_write_ready        (mwr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int mem_lat = 3;
  logic [7:0] mem_data [256];

  typedef struct {
    bit         is_write;
    int         idx;
    logic [7:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t exp_mem[$];
  exp_t exp_done[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic push_read(input int idx, input logic [7:0] a, input logic [7:0] d);
    exp_t e;
    e.is_write = 1'b0; e.idx = idx; e.addr = a; e.data = 8'h00;
    exp_mem.push_back(e);
    e.data = d;
    exp_done.push_back(e);
  endtask

  task automatic push_write(input int idx, input logic [7:0] a, input logic [7:0] d);
    exp_t e;
    e.is_write = 1'b1; e.idx = idx; e.addr = a; e.data = d;
    exp_mem.push_back(e);
    exp_done.push_back(e);
  endtask

  task automatic wait_ready(input int i, input bit is_w);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(negedge clk);
      if (is_w ? wrdy[i] : rrdy[i]) ok = 1'b1;
    end
    check(is_w ? "wait_write_ready" : "wait_read_ready", ok, 1);
  endtask

  task automatic wait_mem_valid(input bit is_w);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(negedge clk);
      if (is_w ? mwv : mrv) ok = 1'b1;
    end
    check(is_w ? "wait_mem_write_valid" : "wait_mem_read_valid", ok, 1);
  endtask

  task automatic c_read(input int i, input logic [7:0] a);
    @(negedge clk);
    rv[i] = 1'b1;
    ra[i*AW +: AW] = a;
    wait_ready(i, 1'b0);
    rv[i] = 1'b0;
    @(negedge clk);
  endtask

  task automatic c_read2(input int i, input logic [7:0] a1, input logic [7:0] a2);
    c_read(i, a1);
    c_read(i, a2);
  endtask

  task automatic c_rw(input int i, input logic [7:0] rda, input logic [7:0] wra, input logic [7:0] wrd);
    @(negedge clk);
    rv[i] = 1'b1;
    wv[i] = 1'b1;
    ra[i*AW +: AW] = rda;
    wa[i*AW +: AW] = wra;
    wd[i*DW +: DW] = wrd;
    wait_ready(i, 1'b0);
    rv[i] = 1'b0;
    wait_ready(i, 1'b1);
    wv[i] = 1'b0;
    @(negedge clk);
  endtask

  // Memory model: acknowledges mem_lat cycles after a request appears; drops it if the request vanishes.
  initial begin
    bit is_w, alive;
    logic [7:0] a;
    int k;
    mrr = 1'b0; mwr = 1'b0; mrd = '0;
    forever begin
      @(negedge clk);
      if (reset && (mrv || mwv)) begin
        is_w  = mwv;
        a     = mwv ? mwa : mra;
        alive = 1'b1;
        k     = 0;
        while (alive && k < mem_lat) begin
          @(negedge clk);
          if (!(is_w ? mwv : mrv)) alive = 1'b0;
          k++;
        end
        if (alive) begin
          if (is_w) begin
            mwr = 1'b1;
            mem_data[a] = mwd;
          end else begin
            mrr = 1'b1;
            mrd = mem_data[a];
          end
          @(negedge clk);
          mrr = 1'b0;
          mwr = 1'b0;
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever a new channel request or consumer completion appears.
  logic            prev_mrv = 1'b0, prev_mwv = 1'b0;
  logic [AW-1:0]   prev_mra = '0, prev_mwa = '0;
  logic [DW-1:0]   prev_mwd = '0;
  logic [N-1:0]    prev_rr = '0, prev_wr = '0;

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      check("one_channel_valid", {63'd0, (mrv && mwv)}, 0);
      check("one_consumer_ready", {63'd0, ($countones({rrdy, wrdy}) <= 1)}, 1);
      if (mrv && prev_mrv) check("mem_read_addr_stable", mra, prev_mra);
      if (mwv && prev_mwv) begin
        check("mem_write_addr_stable", mwa, prev_mwa);
        check("mem_write_data_stable", mwd, prev_mwd);
      end
      if ((mrv && !prev_mrv) || (mwv && !prev_mwv)) begin
        if (exp_mem.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_mem_request: got read=%0b write=%0b expected none", mrv, mwv);
        end else begin
          e = exp_mem.pop_front();
          check("mem_kind", {63'd0, mwv}, {63'd0, e.is_write});
          if (e.is_write) begin
            check("mem_write_addr", mwa, e.addr);
            check("mem_write_data", mwd, e.data);
          end else begin
            check("mem_read_addr", mra, e.addr);
          end
        end
      end
      for (int i = 0; i < N; i++) begin
        if ((rrdy[i] && !prev_rr[i]) || (wrdy[i] && !prev_wr[i])) begin
          if (exp_done.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_completion: got consumer %0d write=%0b expected none", i, wrdy[i]);
          end else begin
            e = exp_done.pop_front();
            check("done_kind", {63'd0, wrdy[i]}, {63'd0, e.is_write});
            check("done_consumer", i, e.idx);
            if (!e.is_write) check("done_read_data", rdata[i*DW +: DW], e.data);
          end
        end
      end
    end
    prev_mrv <= mrv; prev_mwv <= mwv;
    prev_mra <= mra; prev_mwa <= mwa; prev_mwd <= mwd;
    prev_rr  <= rrdy; prev_wr <= wrdy;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rv = '0; wv = '0; ra = '0; wa = '0; wd = '0;
    reset = 1'b0;
    for (int i = 0; i < 256; i++) mem_data[i] = 8'h00;
    mem_data[8'h01] = 8'hB1; mem_data[8'h02] = 8'hB2; mem_data[8'h03] = 8'hB3; mem_data[8'h04] = 8'hB4;
    mem_data[8'h05] = 8'hC5; mem_data[8'h06] = 8'hC6; mem_data[8'h07] = 8'hC7; mem_data[8'h08] = 8'hC8;
    mem_data[8'h10] = 8'hA5; mem_data[8'h33] = 8'h5A; mem_data[8'h30] = 8'h11; mem_data[8'h24] = 8'h77;
    mem_data[8'h60] = 8'hE6; mem_data[8'h50] = 8'hD0; mem_data[8'h52] = 8'hD2;

    repeat (3) @(negedge clk);
    check("reset_ctrl_outputs", {rrdy, wrdy, mrv, mra, mwv, mwa, mwd}, 0);
    check("reset_read_data", rdata, 0);
    reset = 1'b1;

    // Contention: two rounds, all four reading, pointer starting at 0.
    push_read(0, 8'h01, 8'hB1); push_read(1, 8'h02, 8'hB2);
    push_read(2, 8'h03, 8'hB3); push_read(3, 8'h04, 8'hB4);
    push_read(0, 8'h05, 8'hC5); push_read(1, 8'h06, 8'hC6);
    push_read(2, 8'h07, 8'hC7); push_read(3, 8'h08, 8'hC8);
    fork
      c_read2(0, 8'h01, 8'h05);
      c_read2(1, 8'h02, 8'h06);
      c_read2(2, 8'h03, 8'h07);
      c_read2(3, 8'h04, 8'h08);
    join

    // Single read by consumer 2, one-cycle issue latency, ready held until valid drops.
    push_read(2, 8'h10, 8'hA5);
    @(negedge clk);
    rv[2] = 1'b1;
    ra[23:16] = 8'h10;
    @(negedge clk);
    check("t1_latency_valid", mrv, 1);
    check("t1_addr", mra, 8'h10);
    wait_ready(2, 1'b0);
    check("t1_read_data", rdata[23:16], 8'hA5);
    repeat (2) begin
      @(negedge clk);
      check("t1_ready_hold", rrdy[2], 1);
    end
    rv[2] = 1'b0;
    @(negedge clk);
    check("t1_ready_clear", rrdy[2], 0);

    // Wrap fairness: pointer now 3, consumers 0 and 3 -> 3 first.
    push_read(3, 8'h33, 8'h5A);
    push_read(0, 8'h30, 8'h11);
    fork
      c_read(3, 8'h33);
      c_read(0, 8'h30);
    join
    check("non_granted_data_hold", rdata[23:16], 8'hA5);

    // Consumer 1 read and write together: read first, then write.
    push_read(1, 8'h24, 8'h77);
    push_write(1, 8'h20, 8'h3C);
    c_rw(1, 8'h24, 8'h20, 8'h3C);
    push_read(0, 8'h20, 8'h3C);
    c_read(0, 8'h20);

    // Consumer drops valid during READ_WAIT: completes, one-cycle ready.
    push_read(1, 8'h60, 8'hE6);
    @(negedge clk);
    rv[1] = 1'b1;
    ra[15:8] = 8'h60;
    wait_mem_valid(1'b0);
    rv[1] = 1'b0;
    wait_ready(1, 1'b0);
    @(negedge clk);
    check("early_drop_ready_clear", rrdy[1], 0);

    // Reset during WRITE_WAIT of consumer 3 (pointer is 2 here).
    mem_lat = 20;
    begin
      exp_t e;
      e.is_write = 1'b1; e.idx = 3; e.addr = 8'h40; e.data = 8'h99;
      exp_mem.push_back(e);
    end
    @(negedge clk);
    wv[3] = 1'b1;
    wa[31:24] = 8'h40;
    wd[31:24] = 8'h99;
    wait_mem_valid(1'b1);
    repeat (2) @(negedge clk);
    #3 reset = 1'b0;
    #1;
    check("async_reset_ctrl_outputs", {rrdy, wrdy, mrv, mra, mwv, mwa, mwd}, 0);
    check("async_reset_read_data", rdata, 0);
    wv[3] = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    mem_lat = 3;
    @(negedge clk);
    check("no_write_ready_after_release", wrdy, 0);

    // After release arbitration restarts at 0: consumers 0 and 2 -> 0 first.
    push_read(0, 8'h50, 8'hD0);
    push_read(2, 8'h52, 8'hD2);
    fork
      c_read(0, 8'h50);
      c_read(2, 8'h52);
    join

    repeat (5) @(negedge clk);
    check("exp_mem_empty", exp_mem.size(), 0);
    check("exp_done_empty", exp_done.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_BITS, default 8, address width; DATA_BITS, default 8, data width; NUM_CONSUMERS, default 4, number of LSU requesters sharing one data-memory channel.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low. Ports SHALL be, one per line: name  direction  width  meaning.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  asynchronous active-low reset; asserted when 0.
REQ-005 consumer_read_valid  in  NUM_CONSUMERS  per-LSU read request.
REQ-006 consumer_read_address  in  NUM_CONSUMERS x ADDR_BITS  per-LSU read address.
REQ-007 consumer_read_ready  out  NUM_CONSUMERS  per-LSU read completion.
REQ-008 consumer_read_data  out  NUM_CONSUMERS x DATA_BITS  per-LSU returned data.
REQ-009 consumer_write_valid  in  NUM_CONSUMERS  per-LSU write request.
REQ-010 consumer_write_address / consumer_write_data  in  NUM_CONSUMERS x ADDR_BITS / DATA_BITS  per-LSU write address and data.
REQ-011 consumer_write_ready  out  NUM_CONSUMERS  per-LSU write completion.
REQ-012 mem_read_valid / mem_read_address  out  1 / ADDR_BITS  channel read request.
REQ-013 mem_read_ready / mem_read_data  in  1 / DATA_BITS  channel read acknowledge and data.
REQ-014 mem_write_valid / mem_write_address / mem_write_data  out  1 / ADDR_BITS / DATA_BITS  channel write request.
REQ-015 mem_write_ready  in  1  channel write acknowledge.

Function
REQ-016 The FSM SHALL have the states IDLE, READ_WAIT, WRITE_WAIT and RELAY, and SHALL track the granted index and a round-robin pointer rr_ptr.
REQ-017 In IDLE, the FSM SHALL scan consumers rr_ptr, rr_ptr+1, ... mod NUM_CONSUMERS and grant the first one with read_valid or write_valid.
REQ-018 If the granted consumer asserts read_valid and write_valid together, the read SHALL win; the write is served in a later grant.
REQ-019 A request sampled in IDLE at edge N SHALL drive mem_*_valid plus the registered address/data from edge N onward, so latency is one cycle; the next state is READ_WAIT or WRITE_WAIT.
REQ-020 In READ_WAIT/WRITE_WAIT, channel valid, address and data SHALL be held stable until the matching mem_*_ready is sampled high.
REQ-021 On mem_read_ready, the block SHALL deassert mem_read_valid, register mem_read_data into consumer_read_data[g], assert consumer_read_ready[g], and enter RELAY; writes behave the same using consumer_write_ready[g].
REQ-022 In RELAY, consumer_*_ready[g] SHALL stay high until the consumer's corresponding valid is sampled low; then ready SHALL clear, rr_ptr SHALL become (g+1) mod NUM_CONSUMERS (NUM_CONSUMERS-1 wraps to 0), and the FSM SHALL return to IDLE.
REQ-023 A consumer deasserting valid during READ_WAIT/WRITE_WAIT SHALL NOT abort the transaction; it completes and RELAY exits on the next sampled cycle.
REQ-024 At most one channel valid and at most one consumer ready bit SHALL be high in any cycle.
REQ-025 Non-granted consumers' ready SHALL be 0, and their read_data SHALL hold its last value.
REQ-026 With no requests, the FSM SHALL stay in IDLE and rr_ptr SHALL be unchanged.

Reset
REQ-027 While reset is 0, the block SHALL immediately (asynchronously) set state=IDLE, rr_ptr=0 and the grant index to 0, and drive every output (valids, readies, addresses, data) to 0.
REQ-028 Reset asserted mid-transaction SHALL drop the in-flight access without a completion pulse; after release, arbitration SHALL restart from consumer 0.

Structure
REQ-029 The state enum arb_state_t SHALL reside in the shared GPU package, alongside the encoding constants for the core state and LSU state.
REQ-030 Round-robin selection SHALL be a combinational sub-module rr_pick (inputs: request vector, rr_ptr; outputs: grant_valid, grant_index).

Verification
REQ-031 Single read: consumer 2 reads 0x10 and memory returns 0xA5 after 3 cycles -> mem_read_valid goes high 1 cycle after the request, consumer_read_data[2]=0xA5, ready[2] holds until valid drops.
REQ-032 Contention: all 4 consumers read at once, rr_ptr=0 -> grants in order 0,1,2,3; a second round after consumer 3 starts at 0.
REQ-033 Wrap fairness: rr_ptr=3 with consumers 0 and 3 requesting -> 3 is served, then 0.
REQ-034 Same-consumer read and write together (consumer 1, write 0x3C to 0x20) -> the read completes first, then the write with mem_write_data=0x3C, address 0x20.
REQ-035 Reset during WRITE_WAIT -> all outputs are 0 immediately and no write_ready pulse occurs; a new request after release is granted normally.
REQ-036 Checker: no cycle has more than one channel valid or consumer ready high.
